ex_stage_pipe_reg: RTL and testbench
====================================

// Module: ex_stage_pipe_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (next generation of EX/MEM-style latches) with
//  valid/ready handshake, stall back-pressure, flush-to-bubble and an optional 2-entry skid buffer.
//  Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); control bits are zeroed in bubbles
//  so downstream never sees spurious mem_write/reg_write. Payload = DATA_W data + CTRL_W control.
// PARAMETERS
//  DATA_W   32  width of datapath payload (alu_result, write_data, rd ... concatenated)
//  CTRL_W   4   width of control payload (mem_read, mem_write, mem_to_reg, reg_write ...)
//  SKID_EN  1   1: 2-entry skid buffer, o_ready is registered; 0: single entry, o_ready combinational
// PORTS
//  i_clk      in   1       clock, rising edge
//  i_reset_n  in   1       asynchronous active-low reset
//  i_valid    in   1       upstream stage presents a valid instruction
//  o_ready    out  1       this register can accept this cycle
//  i_data     in   DATA_W  upstream datapath payload
//  i_ctrl     in   CTRL_W  upstream control payload
//  i_flush    in   1       kill every held and incoming entry (branch/exception)
//  o_valid    out  1       downstream output entry is valid
//  i_ready    in   1       downstream accepts this cycle (0 = stall)
//  o_data     out  DATA_W  output datapath payload
//  o_ctrl     out  CTRL_W  output control payload; all-zero whenever o_valid=0
//  o_count    out  2       entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  Reset: async on i_reset_n=0: o_valid=0, o_data=0, o_ctrl=0, o_count=0, skid empty, o_ready=1
//   after release (registered o_ready resets to 1). Reset mid-transfer drops all entries.
//  Transfers: in-xfer = i_valid&o_ready; out-xfer = o_valid&i_ready, both sampled at posedge.
//  Latency: accepted entry appears on o_data/o_ctrl the cycle after acceptance (1 cycle).
//  States (SKID_EN=1): EMPTY(count0) / FULL(main valid) / SKID(main+skid valid).
//   EMPTY: in-xfer -> FULL (main<=input).
//   FULL : in&out -> FULL (main<=input); in&!out -> SKID (skid<=input);
//          !in&out -> EMPTY; neither -> FULL (hold).
//   SKID : o_ready=0; out -> FULL (main<=skid); else hold. Order is FIFO, never reordered.
//  SKID_EN=0: o_ready = !o_valid | i_ready (combinational); states EMPTY/FULL only.
//  Stall (i_ready=0): o_data/o_ctrl/o_valid held bit-stable for every stalled cycle.
//  Flush: i_flush=1 at posedge -> next cycle o_valid=0, o_ctrl=0, count=0, skid empty;
//   same-cycle in-xfer is discarded (flush wins); o_data holds last value (don't-care);
//   o_ready=1 the cycle after flush. Flush with reset asserted: reset wins.
//  Bubbles: whenever main is invalid, o_ctrl forced 0 at the register, not by output gating.
//  Simultaneous in&out in SKID state impossible (o_ready=0); upstream must hold data while !o_ready.
//  No combinational path i_valid->o_valid; with SKID_EN=1 none from i_ready->o_ready.
// STRUCTURE
//  Shared package pipe_pkg: localparams for state encoding (ST_EMPTY=2'd0, ST_FULL=2'd1,
//   ST_SKID=2'd2) and default widths EXM_DATA_W=69, EXM_CTRL_W=4 for the EX/MEM instance.
//  One sub-module: pipe_entry_reg (DATA_W+CTRL_W register with load enable and ctrl-clear),
//   instantiated twice (main, skid); FSM + handshake logic in the top module.
//  Generate on SKID_EN removes skid instance and SKID state when 0.
// TESTING
//  1 Reset: drive i_valid=1,i_data=32'hDEAD_BEEF during i_reset_n=0 -> o_valid=0,o_ctrl=0,o_count=0.
//  2 Streaming: i_ready=1, 8 back-to-back valids data=1..8,ctrl=4'b1010 -> outputs 1..8 one cycle
//    later, one per cycle, o_count stays 1, o_ready stays 1.
//  3 Stall: send A=0x11,B=0x22,C=0x33 with i_ready=0 from cycle 2 -> A held on o_data, B in skid,
//    o_count=2, o_ready=0, C not accepted; release i_ready -> A,B,C emerge in order, no loss/dup.
//  4 Flush: count=2 (ctrl=4'b1111), assert i_flush with i_valid=1 -> next cycle o_valid=0,
//    o_ctrl=0, o_count=0, o_ready=1; flushed-cycle input never appears.
//  5 Async reset mid-stall: i_reset_n low between clock edges with count=2 -> outputs clear
//    immediately (before next edge); after release, first new input passes normally.
//  6 SKID_EN=0 build: i_ready toggled randomly 200 cycles with scoreboard -> in-order, lossless,
//    o_count<=1, o_ready == !o_valid|i_ready every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy state
// encoding and default widths for the EX/MEM instance.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_t;

   localparam int EXM_DATA_W = 69;
   localparam int EXM_CTRL_W = 4;

   function automatic logic [1:0] state_count(input pipe_state_t st);
      case (st)
         ST_FULL: return 2'd1;
         ST_SKID: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: datapath plus control payload with load enable.
// Clearing zeroes only the control bits so a bubble can never write anything.
module pipe_entry_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   // Clear beats load, so a kill in the same cycle as a capture leaves a bubble.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         q_data <= '0;
         q_ctrl <= '0;
      end else if (clear) begin
         q_ctrl <= '0;
      end else if (load) begin
         q_data <= d_data;
         q_ctrl <= d_ctrl;
      end
   end

endmodule

// File: rtl/ex_stage_pipe_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble
// and an optional second (skid) entry that lets o_ready be a pure register.
module ex_stage_pipe_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 4,
   parameter int SKID_EN = 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_count
);

   pipe_state_t       state_q, state_d;
   logic              in_xfer, out_xfer;
   logic              main_load, main_clear, main_from_skid;
   logic              skid_load, skid_clear;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   assign in_xfer  = i_valid & o_ready;
   assign out_xfer = o_valid & i_ready;
   assign o_valid  = (state_q != ST_EMPTY);
   assign o_count  = state_count(state_q);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= ST_EMPTY;
      else            state_q <= state_d;
   end

   // Occupancy FSM; the skid entry only ever fills while the main entry is stalled.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (i_flush) begin
         state_d    = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d   = ST_FULL;
                  main_load = 1'b1;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_load = 1'b1;
               end else if (in_xfer && (SKID_EN != 0)) begin
                  state_d   = ST_SKID;
                  skid_load = 1'b1;
               end else if (out_xfer) begin
                  state_d    = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
            ST_SKID: begin
               if (out_xfer) begin
                  state_d        = ST_FULL;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .load      (main_load),
      .clear     (main_clear),
      .d_data    (main_from_skid ? skid_data : i_data),
      .d_ctrl    (main_from_skid ? skid_ctrl : i_ctrl),
      .q_data    (o_data),
      .q_ctrl    (o_ctrl)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         logic ready_q;

         pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .load      (skid_load),
            .clear     (skid_clear),
            .d_data    (i_data),
            .d_ctrl    (i_ctrl),
            .q_data    (skid_data),
            .q_ctrl    (skid_ctrl)
         );

         // Ready is precomputed from the next state, breaking the i_ready->o_ready path.
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) ready_q <= 1'b1;
            else            ready_q <= (state_d != ST_SKID);
         end

         assign o_ready = ready_q;
      end else begin : g_no_skid
         logic unused_skid;
         assign unused_skid = skid_load ^ skid_clear;
         assign skid_data   = '0;
         assign skid_ctrl   = '0;
         assign o_ready     = !o_valid || i_ready;
      end
   endgenerate

endmodule

// File: tb/tb_ex_stage_pipe_reg.sv
// Bench for ex_stage_pipe_reg: a skid build (a) and a single-entry build (z)
// side by side, both checked every cycle against queue-based reference models.
module tb_ex_stage_pipe_reg;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  c;
   } ent_t;

   logic        i_clk = 1'b0;
   logic        i_reset_n;

   logic        i_valid_a, o_ready_a, i_flush_a, o_valid_a, i_ready_a;
   logic [31:0] i_data_a, o_data_a;
   logic [3:0]  i_ctrl_a, o_ctrl_a;
   logic [1:0]  o_count_a;

   logic        i_valid_z, o_ready_z, i_flush_z, o_valid_z, i_ready_z;
   logic [31:0] i_data_z, o_data_z;
   logic [3:0]  i_ctrl_z, o_ctrl_z;
   logic [1:0]  o_count_z;

   ent_t qa[$];
   ent_t qz[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   acc_a, acc_z;

   always #5 i_clk = ~i_clk;

   ex_stage_pipe_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(1)) dut_a (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid_a), .o_ready(o_ready_a),
      .i_data(i_data_a), .i_ctrl(i_ctrl_a), .i_flush(i_flush_a), .o_valid(o_valid_a),
      .i_ready(i_ready_a), .o_data(o_data_a), .o_ctrl(o_ctrl_a), .o_count(o_count_a)
   );

   ex_stage_pipe_reg #(.DATA_W(32), .CTRL_W(4), .SKID_EN(0)) dut_z (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid_z), .o_ready(o_ready_z),
      .i_data(i_data_z), .i_ctrl(i_ctrl_z), .i_flush(i_flush_z), .o_valid(o_valid_z),
      .i_ready(i_ready_z), .o_data(o_data_z), .o_ctrl(o_ctrl_z), .o_count(o_count_z)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_output(input string lbl);
      check({lbl, ".a_valid"}, o_valid_a, qa.size() > 0);
      check({lbl, ".a_count"}, o_count_a, 64'(qa.size()));
      check({lbl, ".a_ready"}, o_ready_a, qa.size() < 2);
      check({lbl, ".a_ctrl"},  o_ctrl_a, (qa.size() > 0) ? qa[0].c : 4'd0);
      if (qa.size() > 0) check({lbl, ".a_data"}, o_data_a, qa[0].d);
      check({lbl, ".z_valid"}, o_valid_z, qz.size() > 0);
      check({lbl, ".z_count"}, o_count_z, 64'(qz.size()));
      check({lbl, ".z_cnt_le1"}, o_count_z <= 2'd1, 1'b1);
      check({lbl, ".z_ready"}, o_ready_z, (qz.size() == 0) || i_ready_z);
      check({lbl, ".z_ctrl"},  o_ctrl_z, (qz.size() > 0) ? qz[0].c : 4'd0);
      if (qz.size() > 0) check({lbl, ".z_data"}, o_data_z, qz[0].d);
   endtask

   // One clock: the models take the transfers seen at the edge, then outputs are checked.
   task automatic apply_stimulus(input string lbl);
      bit in_a, out_a, in_z, out_z;
      ent_t ea, ez;
      @(posedge i_clk);
      cyc++;
      in_a  = i_valid_a && (qa.size() < 2);
      out_a = (qa.size() > 0) && i_ready_a;
      in_z  = i_valid_z && ((qz.size() == 0) || i_ready_z);
      out_z = (qz.size() > 0) && i_ready_z;
      ea = '{d: i_data_a, c: i_ctrl_a};
      ez = '{d: i_data_z, c: i_ctrl_z};
      acc_a = 1'b0;
      acc_z = 1'b0;
      if (i_reset_n) begin
         if (i_flush_a) qa.delete();
         else begin
            if (out_a) void'(qa.pop_front());
            if (in_a) begin qa.push_back(ea); acc_a = 1'b1; end
         end
         if (i_flush_z) qz.delete();
         else begin
            if (out_z) void'(qz.pop_front());
            if (in_z) begin qz.push_back(ez); acc_z = 1'b1; end
         end
      end
      #1;
      check_output(lbl);
   endtask

   task automatic send_a(input logic [31:0] d, input logic [3:0] c, input string lbl);
      int n;
      i_valid_a = 1'b1;
      i_data_a  = d;
      i_ctrl_a  = c;
      n = 0;
      do begin
         apply_stimulus(lbl);
         n++;
      end while (!acc_a && n < 20);
      if (!acc_a) begin
         total++;
         bad++;
         $error("[TB] FAIL %s_timeout observed=notaccepted expected=accepted", lbl);
      end
      i_valid_a = 1'b0;
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_valid_a = 1'b1; i_data_a = 32'hDEAD_BEEF; i_ctrl_a = 4'hF; i_flush_a = 1'b0; i_ready_a = 1'b1;
      i_valid_z = 1'b1; i_data_z = 32'hDEAD_BEEF; i_ctrl_z = 4'hF; i_flush_z = 1'b0; i_ready_z = 1'b1;

      // Reset with active input
      repeat (3) @(posedge i_clk);
      #1;
      check("rst.a_valid", o_valid_a, 1'b0);
      check("rst.a_ctrl",  o_ctrl_a, 4'd0);
      check("rst.a_count", o_count_a, 2'd0);
      check("rst.z_valid", o_valid_z, 1'b0);
      check("rst.z_ctrl",  o_ctrl_z, 4'd0);
      i_valid_a = 1'b0;
      i_valid_z = 1'b0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      #1;
      check_output("rst_release");

      // Streaming
      for (int k = 1; k <= 8; k++) begin
         i_valid_a = 1'b1; i_data_a = 32'(k); i_ctrl_a = 4'b1010;
         apply_stimulus("stream");
         check("stream.data",  o_data_a, 32'(k));
         check("stream.count", o_count_a, 2'd1);
         check("stream.ready", o_ready_a, 1'b1);
      end
      i_valid_a = 1'b0;
      apply_stimulus("stream_drain");

      // Stall into skid, C refused, then drain in order
      i_valid_a = 1'b1; i_data_a = 32'h11; i_ctrl_a = 4'b0011;
      apply_stimulus("stall_a");
      i_ready_a = 1'b0; i_data_a = 32'h22;
      apply_stimulus("stall_b");
      i_data_a = 32'h33;
      repeat (3) apply_stimulus("stall_c");
      check("stall.data",    o_data_a, 32'h11);
      check("stall.count",   o_count_a, 2'd2);
      check("stall.ready",   o_ready_a, 1'b0);
      check("stall.c_taken", acc_a, 1'b0);
      i_ready_a = 1'b1;
      apply_stimulus("stall_rel");
      check("stall.second", o_data_a, 32'h22);
      send_a(32'h33, 4'b0011, "stall_c_send");
      check("stall.third", o_data_a, 32'h33);
      repeat (2) apply_stimulus("stall_drain");

      // Flush with two entries held
      i_ready_a = 1'b0;
      send_a(32'h44, 4'b1111, "fl_fill1");
      send_a(32'h55, 4'b1111, "fl_fill2");
      i_flush_a = 1'b1; i_valid_a = 1'b1; i_data_a = 32'h99; i_ctrl_a = 4'b1111;
      apply_stimulus("flush2");
      check("flush2.valid", o_valid_a, 1'b0);
      check("flush2.ctrl",  o_ctrl_a, 4'd0);
      check("flush2.count", o_count_a, 2'd0);
      check("flush2.ready", o_ready_a, 1'b1);
      i_flush_a = 1'b0; i_valid_a = 1'b0; i_ready_a = 1'b1;
      repeat (3) apply_stimulus("flush2_after");

      // Flush while an input would otherwise be accepted
      i_ready_a = 1'b0;
      send_a(32'h66, 4'b0101, "fl1_fill");
      i_flush_a = 1'b1; i_valid_a = 1'b1; i_data_a = 32'h77; i_ctrl_a = 4'b1111;
      apply_stimulus("flush1");
      check("flush1.valid", o_valid_a, 1'b0);
      i_flush_a = 1'b0; i_valid_a = 1'b0; i_ready_a = 1'b1;
      repeat (2) apply_stimulus("flush1_after");

      // Async reset between edges while full
      i_ready_a = 1'b0;
      send_a(32'h81, 4'b1111, "ar_fill1");
      send_a(32'h82, 4'b1111, "ar_fill2");
      #2;
      i_reset_n = 1'b0;
      #1;
      check("areset.valid", o_valid_a, 1'b0);
      check("areset.ctrl",  o_ctrl_a, 4'd0);
      check("areset.count", o_count_a, 2'd0);
      qa.delete();
      qz.delete();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      i_ready_a = 1'b1;
      send_a(32'h5A, 4'b0110, "areset_new");
      check("areset.new_data", o_data_a, 32'h5A);
      apply_stimulus("areset_drain");

      // Random traffic on both builds
      acc_a = 1'b0;
      acc_z = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!i_valid_a || acc_a) begin
            i_valid_a = 1'($urandom_range(0, 1));
            i_data_a  = $urandom;
            i_ctrl_a  = 4'($urandom);
         end
         if (!i_valid_z || acc_z) begin
            i_valid_z = 1'($urandom_range(0, 1));
            i_data_z  = $urandom;
            i_ctrl_z  = 4'($urandom);
         end
         i_ready_a = ($urandom_range(0, 3) != 0);
         i_ready_z = 1'($urandom_range(0, 1));
         apply_stimulus("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
